// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch byte assembler on the IF request path. Given a PC it asks
// the memory controller for four consecutive bytes (base, base+1, base+2,
// base+3), packs them little-endian into a 32-bit instruction and offers the
// instruction and its PC to decode with a valid/ready handshake.
//
// Handshake: inst_o/inst_pc_o are valid while inst_valid_o=1 and stay stable
// until decode raises id_ready_i. The transfer happens at the rising edge where
// inst_valid_o=1 and id_ready_i=1. A new PC is taken on pc_valid_i in IDLE,
// in VALID together with that transfer, or together with flush_i. pc_valid_i
// is ignored while fetching.
//
// Ports:
//   clk_i         clock, all state changes on the rising edge
//   rst_i         synchronous, active-low reset
//   pc_i          fetch PC
//   pc_valid_i    fetch request
//   mem_gnt_i     controller grants IF the RAM this cycle
//   mem_byte_i    RAM read data, valid the cycle after a granted request
//   if_mem_req_o  IF memory request
//   mem_addr_o    byte address of the current request (0 when not requesting)
//   inst_o        assembled instruction
//   inst_pc_o     PC of inst_o
//   inst_valid_o  inst_o/inst_pc_o valid
//   id_ready_i    decode accepts the instruction
//   flush_i       discard everything in flight (highest priority)
//   misalign_o    only with IF_MISALIGN_TRAP_EN: NOP substituted for a
//                 misaligned PC
//   busy_o        unit not idle
//
// Build option: define IF_MISALIGN_TRAP_EN to trap misaligned PCs instead of
// fetching them byte-wise.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int ADDR_W     = 32,
    parameter int INST_BYTES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_byte_i,
    output logic              if_mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              id_ready_i,
    input  logic              flush_i,
`ifdef IF_MISALIGN_TRAP_EN
    output logic              misalign_o,
`endif
    output logic              busy_o
);

    localparam logic [2:0]  NUM_BYTES = 3'(INST_BYTES);
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] base;
    logic [2:0]        issue_cnt;
    logic [2:0]        recv_cnt;
    logic              rd_pending;
    logic [1:0]        rd_idx;
    logic [31:0]       inst_buf;

    logic              start_fetch;
    logic              accept;
    logic              capture_last;
    logic              trap;
    logic [31:0]       assembled;

    // A new PC is taken in IDLE, on the decode handshake in VALID, or with a
    // flush from any state.
    assign start_fetch = pc_valid_i &
                         (flush_i || (state == IDLE) || (state == VALID && id_ready_i));

`ifdef IF_MISALIGN_TRAP_EN
    assign trap = start_fetch & (pc_i[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    assign if_mem_req_o = (state == FETCH) && (issue_cnt < NUM_BYTES);
    assign mem_addr_o   = if_mem_req_o ? (base + ADDR_W'(issue_cnt)) : '0;
    assign accept       = if_mem_req_o & mem_gnt_i;
    assign busy_o       = (state != IDLE);

    // Last byte arrives this cycle; a flush on the same edge wins.
    assign capture_last = (state == FETCH) && rd_pending &&
                          (recv_cnt == NUM_BYTES - 3'd1) && !flush_i;

    // Working word with the returning byte dropped into its slot.
    always_comb begin
        assembled = inst_buf;
        assembled[{3'b000, rd_idx} * 8 +: 8] = mem_byte_i;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        if (flush_i) begin
            state_d = pc_valid_i ? FETCH : IDLE;
        end else begin
            case (state)
                IDLE:    if (pc_valid_i) state_d = FETCH;
                FETCH:   if (capture_last) state_d = VALID;
                VALID:   if (id_ready_i) state_d = pc_valid_i ? FETCH : IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (trap) state_d = VALID;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_d;
    end

    // Fetch datapath
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            base       <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            rd_pending <= 1'b0;
            rd_idx     <= '0;
            inst_buf   <= '0;
        end else begin
            if (start_fetch || flush_i) begin
                // Dropping rd_pending makes the byte already in flight vanish.
                issue_cnt  <= '0;
                recv_cnt   <= '0;
                rd_pending <= 1'b0;
            end else if (state == FETCH) begin
                rd_pending <= accept;
                if (accept) begin
                    issue_cnt <= issue_cnt + 3'd1;
                    rd_idx    <= issue_cnt[1:0];
                end
                if (rd_pending) begin
                    inst_buf <= assembled;
                    recv_cnt <= recv_cnt + 3'd1;
                end
            end
            if (start_fetch) begin
                base     <= pc_i;
                inst_buf <= '0;
            end
        end
    end

    // Decode-facing output registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_o   <= 1'b0;
`endif
        end else if (trap) begin
            inst_o       <= NOP_INST;
            inst_pc_o    <= pc_i;
            inst_valid_o <= 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_o   <= 1'b1;
`endif
        end else if (flush_i || (state == VALID && id_ready_i)) begin
            // inst_o/inst_pc_o keep their last value; only valid drops.
            inst_valid_o <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_o   <= 1'b0;
`endif
        end else if (capture_last) begin
            inst_o       <= assembled;
            inst_pc_o    <= base;
            inst_valid_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Inputs are driven 1 ns after each rising
// edge ("cycle start") and outputs are sampled at that same point; all DUT
// outputs depend only on registers.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        mem_gnt_i;
    logic [7:0]  mem_byte_i;
    logic        if_mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        id_ready_i;
    logic        flush_i;
    logic        busy_o;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.ADDR_W(32), .INST_BYTES(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .mem_gnt_i    (mem_gnt_i),
        .mem_byte_i   (mem_byte_i),
        .if_mem_req_o (if_mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .id_ready_i   (id_ready_i),
        .flush_i      (flush_i),
`ifdef IF_MISALIGN_TRAP_EN
        .misalign_o   (misalign_o),
`endif
        .busy_o       (busy_o)
    );

    // RAM contents
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h13;
            32'h0000_0101: return 8'h05;
            32'h0000_0102: return 8'h00;
            32'h0000_0103: return 8'h00;
            32'h0000_0104: return 8'h93;
            32'h0000_0105: return 8'h02;
            32'h0000_0106: return 8'h10;
            32'h0000_0107: return 8'h00;
            32'h0000_0200: return 8'hb3;
            32'h0000_0201: return 8'h85;
            32'h0000_0202: return 8'hc5;
            32'h0000_0203: return 8'h00;
            32'hFFFF_FFFE: return 8'h11;
            32'hFFFF_FFFF: return 8'h22;
            32'h0000_0000: return 8'h33;
            32'h0000_0001: return 8'h44;
            default:       return a[7:0] ^ 8'h5a;
        endcase
    endfunction

    // Byte returns the cycle after a granted request; otherwise junk.
    always @(posedge clk) begin
        if (if_mem_req_o && mem_gnt_i) mem_byte_i <= ram_rd(mem_addr_o);
        else                           mem_byte_i <= 8'hee;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for inst_valid_o, then check it is set.
    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && inst_valid_o !== 1'b1; i++) step();
        chk("valid_arrives", {31'd0, inst_valid_o}, 32'd1);
    endtask

    task automatic handshake();
        id_ready_i = 1'b1;
        step();
        id_ready_i = 1'b0;
        chk("hs_valid_low", {31'd0, inst_valid_o}, 32'd0);
        chk("hs_idle", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; pc_i = '0; pc_valid_i = 1'b0; mem_gnt_i = 1'b1;
        id_ready_i = 1'b0; flush_i = 1'b0;
        step();
        step();
        chk("rst_req", {31'd0, if_mem_req_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", inst_pc_o, 32'd0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b1;
        step();

        // Basic fetch at 0x100, continuous grant
        pc_i = 32'h100; pc_valid_i = 1'b1;          // cycle 0
        step();                                      // cycle 1
        pc_valid_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("t1_req", {31'd0, if_mem_req_o}, 32'd1);
            chk("t1_addr", mem_addr_o, 32'h100 + 32'(c - 1));
            chk("t1_busy", {31'd0, busy_o}, 32'd1);
            step();
        end
        chk("t1_c5_req", {31'd0, if_mem_req_o}, 32'd0);   // cycle 5
        chk("t1_c5_valid", {31'd0, inst_valid_o}, 32'd0);
        step();                                           // cycle 6
        chk("t1_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("t1_inst", inst_o, 32'h0000_0513);
        chk("t1_pc", inst_pc_o, 32'h100);

        // Decode stalls for 5 cycles
        for (int c = 0; c < 5; c++) begin
            step();
            chk("hold_valid", {31'd0, inst_valid_o}, 32'd1);
            chk("hold_inst", inst_o, 32'h0000_0513);
            chk("hold_pc", inst_pc_o, 32'h100);
        end
        // Handshake with back-to-back PC 0x104
        id_ready_i = 1'b1; pc_valid_i = 1'b1; pc_i = 32'h104;
        step();
        id_ready_i = 1'b0; pc_valid_i = 1'b0;
        chk("b2b_req", {31'd0, if_mem_req_o}, 32'd1);
        chk("b2b_addr", mem_addr_o, 32'h104);
        chk("b2b_valid", {31'd0, inst_valid_o}, 32'd0);
        wait_valid(10);
        chk("b2b_inst", inst_o, 32'h0010_0293);
        chk("b2b_pc", inst_pc_o, 32'h104);
        handshake();

        // Grant withheld in cycles 2-3
        pc_i = 32'h100; pc_valid_i = 1'b1;          // cycle 0
        step();                                      // cycle 1
        pc_valid_i = 1'b0;
        chk("gap_c1_addr", mem_addr_o, 32'h100);
        step();                                      // cycle 2
        mem_gnt_i = 1'b0;
        chk("gap_c2_addr", mem_addr_o, 32'h101);
        chk("gap_c2_req", {31'd0, if_mem_req_o}, 32'd1);
        step();                                      // cycle 3
        chk("gap_c3_addr", mem_addr_o, 32'h101);
        chk("gap_c3_req", {31'd0, if_mem_req_o}, 32'd1);
        step();                                      // cycle 4
        mem_gnt_i = 1'b1;
        chk("gap_c4_addr", mem_addr_o, 32'h101);
        step(); step(); step();                      // cycle 7
        chk("gap_c7_valid", {31'd0, inst_valid_o}, 32'd0);
        step();                                      // cycle 8
        chk("gap_c8_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("gap_inst", inst_o, 32'h0000_0513);
        handshake();

        // Flush with redirect to 0x200 in cycle 3 of a fetch at 0x100
        pc_i = 32'h100; pc_valid_i = 1'b1;          // cycle 0
        step();                                      // cycle 1
        pc_valid_i = 1'b0;
        step();                                      // cycle 2
        step();                                      // cycle 3
        flush_i = 1'b1; pc_valid_i = 1'b1; pc_i = 32'h200;
        step();                                      // cycle 4
        flush_i = 1'b0; pc_valid_i = 1'b0;
        chk("fl_req", {31'd0, if_mem_req_o}, 32'd1);
        chk("fl_addr", mem_addr_o, 32'h200);
        for (int c = 5; c <= 8; c++) begin
            step();
            chk("fl_no_valid", {31'd0, inst_valid_o}, 32'd0);
        end
        step();                                      // cycle 9
        chk("fl_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("fl_inst", inst_o, 32'h00c5_85b3);
        chk("fl_pc", inst_pc_o, 32'h200);
        handshake();

        // Reset in cycle 3 of a fetch
        pc_i = 32'h104; pc_valid_i = 1'b1;          // cycle 0
        step();
        pc_valid_i = 1'b0;
        step();
        step();                                      // cycle 3
        rst_i = 1'b0;
        step();                                      // cycle 4
        rst_i = 1'b1;
        chk("mr_req", {31'd0, if_mem_req_o}, 32'd0);
        chk("mr_addr", mem_addr_o, 32'd0);
        chk("mr_inst", inst_o, 32'd0);
        chk("mr_pc", inst_pc_o, 32'd0);
        chk("mr_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("mr_busy", {31'd0, busy_o}, 32'd0);
        step();
        chk("mr_c5_busy", {31'd0, busy_o}, 32'd0);
        chk("mr_c5_inst", inst_o, 32'd0);

        // Fetch across the top of the address space
        pc_i = 32'hFFFF_FFFE; pc_valid_i = 1'b1;    // cycle 0
        step();                                      // cycle 1
        pc_valid_i = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        chk("mis_req", {31'd0, if_mem_req_o}, 32'd0);
        chk("mis_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("mis_inst", inst_o, 32'h0000_0013);
        chk("mis_pc", inst_pc_o, 32'hFFFF_FFFE);
        chk("mis_flag", {31'd0, misalign_o}, 32'd1);
        handshake();
        chk("mis_flag_clr", {31'd0, misalign_o}, 32'd0);
`else
        chk("wrap_a0", mem_addr_o, 32'hFFFF_FFFE);
        step();
        chk("wrap_a1", mem_addr_o, 32'hFFFF_FFFF);
        step();
        chk("wrap_a2", mem_addr_o, 32'h0000_0000);
        step();
        chk("wrap_a3", mem_addr_o, 32'h0000_0001);
        step();                                      // cycle 5
        step();                                      // cycle 6
        chk("wrap_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("wrap_inst", inst_o, 32'h4433_2211);
        chk("wrap_pc", inst_pc_o, 32'hFFFF_FFFE);
        handshake();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch byte assembler that sits directly upstream of the memory controller on the IF request path.
- Takes a PC and issues four byte-read requests (addr, addr+1, addr+2, addr+3) to the byte-wide RAM through the controller.
- Collects the returned bytes little-endian into a 32-bit instruction.
- Hands the instruction and its PC to decode with a valid/ready handshake.
- Yields to MEM-stage traffic via a grant input and supports pipeline flush/redirect.

Parameters:
ADDR_W, 32, width of byte addresses and PC
INST_BYTES, 4, bytes per instruction; fixed at 4, other values unsupported

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-low reset
pc_i  in  ADDR_W  fetch PC
pc_valid_i  in  1  fetch request; pc_i accepted when unit can take it
mem_gnt_i  in  1  controller grants IF access this cycle (low when MEM stage owns RAM)
mem_byte_i  in  8  RAM read data; valid the cycle after a granted request
if_mem_req_o  out  1  IF memory request
mem_addr_o  out  ADDR_W  byte address of current request
inst_o  out  32  assembled instruction
inst_pc_o  out  ADDR_W  PC of inst_o
inst_valid_o  out  1  inst_o/inst_pc_o valid
id_ready_i  in  1  decode accepts instruction
flush_i  in  1  discard everything in flight
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i==0 at edge):
  - state=IDLE; issue_cnt=0, recv_cnt=0, rd_pending=0.
  - inst_o=0, inst_pc_o=0, inst_valid_o=0.
  - if_mem_req_o=0, mem_addr_o=0, busy_o=0.
  - Reset mid-fetch aborts; the late RAM byte is ignored.
- States: IDLE, FETCH, VALID.
- IDLE: pc_valid_i=1 -> latch base=pc_i, clear counters, go FETCH.
- FETCH:
  - Outputs (combinational from regs): if_mem_req_o = (issue_cnt<4); mem_addr_o = base + issue_cnt (mod 2^ADDR_W, wraps at top of space).
  - Accept when if_mem_req_o & mem_gnt_i at an edge: issue_cnt++, rd_pending<=1, rd_idx<=issue_cnt.
  - No grant -> counters hold, request and address stay stable.
  - rd_pending=1 at an edge: byte slot rd_idx <= mem_byte_i, recv_cnt++, rd_pending<=0 unless a new request is accepted the same edge.
  - Byte k goes to inst bits [8k+7:8k].
  - When the 4th byte is captured: inst_o, inst_pc_o=base, inst_valid_o<=1, go VALID.
- Latency with continuous grant: pc_valid_i sampled end of cycle 0; requests in cycles 1-4; bytes captured end of cycles 2-5; inst_valid_o=1 in cycle 6.
- Each grant gap adds exactly one cycle per denied cycle.
- VALID: outputs hold stable while id_ready_i=0.
  - On id_ready_i=1: inst_valid_o<=0.
  - If pc_valid_i=1 in the same cycle: latch new base, go FETCH (back-to-back, no bubble in IDLE). Otherwise go IDLE.
- pc_valid_i is ignored in FETCH (no queueing); the upstream PC unit holds it.
- flush_i=1 (any state) has priority over all other events:
  - inst_valid_o<=0, rd_pending<=0, counters cleared.
  - Byte returned the following cycle is discarded.
  - If pc_valid_i=1 in the same cycle: latch pc_i and go FETCH. Else go IDLE.
- busy_o = (state!=IDLE).

Optional Feature:
IF_MISALIGN_TRAP_EN.
- Defined: adds output misalign_o (1 bit, reset 0).
  - A pc_i with pc_i[1:0]!=0 accepted in IDLE/VALID produces no memory requests.
  - Next cycle: state=VALID, inst_o=32'h00000013 (NOP), inst_pc_o=pc_i, inst_valid_o=1, misalign_o=1.
  - misalign_o clears with the id_ready_i handshake or flush.
- Undefined: no misalign_o port; any alignment is fetched byte-wise normally.

Test Plan:
- Reset then pc_valid_i=1, pc_i=0x100, gnt always 1, RAM[0x100..0x103]=13,05,00,00 -> requests 0x100-0x103 in cycles 1-4, inst_valid_o=1 cycle 6, inst_o=0x00000513, inst_pc_o=0x100.
- Same fetch with mem_gnt_i=0 for cycles 2-3 -> mem_addr_o holds 0x101 for those cycles, inst_valid_o arrives cycle 8, inst_o unchanged value.
- Hold id_ready_i=0 for 5 cycles in VALID -> inst_o/inst_pc_o/inst_valid_o stable; then id_ready_i=1 with pc_valid_i=1, pc_i=0x104 -> if_mem_req_o=1, mem_addr_o=0x104 next cycle.
- flush_i=1 with pc_valid_i=1, pc_i=0x200 in cycle 3 of fetch at 0x100 -> no valid for 0x100; next request 0x200; result assembles only RAM[0x200..0x203].
- rst_i=0 during cycle 3 of a fetch -> all outputs 0 next cycle, busy_o=0, stale byte not captured.
- pc_i=0xFFFFFFFE (feature off) -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; with IF_MISALIGN_TRAP_EN: no requests, inst_o=0x13, misalign_o=1 next cycle.
